// File: rtl/crash_detector_if.sv
// Signal bundle between the colour mapper / game FSM side and crash_detector.
// frame_start is a one-cycle strobe; pixel flags count only when pix_valid=1; there is no backpressure.
interface crash_detector_if #(
    parameter int CNT_W = 12
);
    logic             Run;
    logic             frame_start;
    logic             pix_valid;
    logic             ship_pix;
    logic             obst_pix;
    logic [9:0]       ship_x;
    logic [9:0]       ship_y;
    logic             crash;
    logic [1:0]       crash_cause;
    logic [CNT_W-1:0] overlap_count;
    logic [1:0]       state;

    modport master (
        output Run, frame_start, pix_valid, ship_pix, obst_pix, ship_x, ship_y,
        input  crash, crash_cause, overlap_count, state
    );

    modport slave (
        input  Run, frame_start, pix_valid, ship_pix, obst_pix, ship_x, ship_y,
        output crash, crash_cause, overlap_count, state
    );
endinterface

// File: rtl/crash_detector.sv
// Sticky crash flag for the game FSM: sustained ship/obstacle overlap or out-of-bounds position.
// Optional post-start grace period enabled by macro CRASH_DETECTOR_GRACE_EN.
module crash_detector #(
    parameter int         CNT_W        = 12,
    parameter int         HIT_THRESH   = 4,
    parameter int         CRASH_FRAMES = 2,
    parameter logic [9:0] X_MAX        = 10'd639,
    parameter logic [9:0] Y_MAX        = 10'd479
`ifdef CRASH_DETECTOR_GRACE_EN
    , parameter int       GRACE_FRAMES = 60
`endif
) (
    input  logic             Clk,
    input  logic             Reset,
    crash_detector_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CRASHED = 2'd2} state_t;

    localparam int CONS_W = $clog2(CRASH_FRAMES + 1);
    localparam logic [CNT_W-1:0]  THR     = CNT_W'(HIT_THRESH);
    localparam logic [CONS_W:0]   CF      = (CONS_W + 1)'(CRASH_FRAMES);
    localparam logic [CNT_W-1:0]  ACC_MAX = '1;
    localparam logic [CONS_W-1:0] CON_MAX = '1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   acc, acc_n, ovc, ovc_n;
    logic [CONS_W-1:0]  consec, consec_n;
    logic               synced, synced_n;
    logic               crash, crash_n;
    logic [1:0]         cause, cause_n;
    logic               hit_pix, frame_hit, ovl, bnd, eval_en;
    logic [CONS_W:0]    consec_p1;

`ifdef CRASH_DETECTOR_GRACE_EN
    localparam int GR_W = $clog2(GRACE_FRAMES + 1);
    logic [GR_W-1:0] grace, grace_n;
`endif

    assign hit_pix   = bus.pix_valid & bus.ship_pix & bus.obst_pix;
    assign frame_hit = (acc >= THR);
    assign consec_p1 = {1'b0, consec} + 1'b1;
    assign ovl       = frame_hit && (consec_p1 >= CF);
    assign bnd       = (bus.ship_x > X_MAX) || (bus.ship_y > Y_MAX);
`ifdef CRASH_DETECTOR_GRACE_EN
    assign eval_en   = (grace == '0);
`else
    assign eval_en   = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        ovc_n    = ovc;
        consec_n = consec;
        synced_n = synced;
        crash_n  = crash;
        cause_n  = cause;
`ifdef CRASH_DETECTOR_GRACE_EN
        grace_n  = grace;
`endif
        case (state)
            IDLE: begin
                acc_n    = '0;
                consec_n = '0;
                if (bus.Run) begin
                    state_n = ARMED;
`ifdef CRASH_DETECTOR_GRACE_EN
                    grace_n = GR_W'(GRACE_FRAMES);
`endif
                end
            end
            ARMED: begin
                if (!bus.Run) begin
                    // Run dropping beats a coincident frame_start: no evaluation
                    state_n  = IDLE;
                    acc_n    = '0;
                    consec_n = '0;
                    synced_n = 1'b0;
                end else if (bus.frame_start) begin
                    // The pixel on the strobe cycle belongs to the new frame
                    acc_n = {{(CNT_W-1){1'b0}}, hit_pix};
                    if (!synced) begin
                        synced_n = 1'b1;
                    end else begin
                        ovc_n = acc;
                        if (eval_en) begin
                            consec_n = frame_hit ? ((consec == CON_MAX) ? consec : consec + 1'b1) : '0;
                            if (ovl || bnd) begin
                                state_n = CRASHED;
                                crash_n = 1'b1;
                                cause_n = {bnd, ovl};
                            end
                        end else begin
                            consec_n = '0;
`ifdef CRASH_DETECTOR_GRACE_EN
                            grace_n  = grace - 1'b1;
`endif
                        end
                    end
                end else if (hit_pix && acc != ACC_MAX) begin
                    acc_n = acc + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            acc    <= '0;
            ovc    <= '0;
            consec <= '0;
            synced <= 1'b0;
            crash  <= 1'b0;
            cause  <= 2'b00;
`ifdef CRASH_DETECTOR_GRACE_EN
            grace  <= '0;
`endif
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            ovc    <= ovc_n;
            consec <= consec_n;
            synced <= synced_n;
            crash  <= crash_n;
            cause  <= cause_n;
`ifdef CRASH_DETECTOR_GRACE_EN
            grace  <= grace_n;
`endif
        end
    end

    assign bus.crash         = crash;
    assign bus.crash_cause   = cause;
    assign bus.overlap_count = ovc;
    assign bus.state         = state;
endmodule

// File: tb/tb_crash_detector.sv
// Directed bench for crash_detector: scoreboard of expected {crash, cause, overlap_count} per step.
module tb_crash_detector;
    localparam int CNT_W = 12;
    localparam int W     = CNT_W + 3;
`ifdef CRASH_DETECTOR_GRACE_EN
    localparam int GF = 3;
`else
    localparam int GF = 0;
`endif
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CRASHED = 2'd2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    crash_detector_if #(.CNT_W(CNT_W)) bus();

`ifdef CRASH_DETECTOR_GRACE_EN
    crash_detector #(.CNT_W(CNT_W), .GRACE_FRAMES(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
`else
    crash_detector #(.CNT_W(CNT_W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
`endif

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic c, input logic [1:0] cause, input logic [CNT_W-1:0] cnt);
        exp_q.push_back({c, cause, cnt});
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s observed=no-expectation expected=queued-entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, 32'({bus.crash, bus.crash_cause, bus.overlap_count}), 32'(e));
        end
    endtask

    task automatic cyc(input logic fs, input logic hit);
        @(negedge Clk);
        bus.frame_start = fs;
        bus.pix_valid   = 1'b1;
        bus.ship_pix    = 1'b1;
        bus.obst_pix    = hit;
        @(posedge Clk);
        #1;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic close(input logic hit, input logic [9:0] x = 10'd100, input logic [9:0] y = 10'd100);
        bus.ship_x = x;
        bus.ship_y = y;
        cyc(1'b1, hit);
        bus.ship_x = 10'd100;
        bus.ship_y = 10'd100;
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        bus.Run = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    // Enter ARMED, take the sync pulse, then burn any grace frames with clean frames
    task automatic arm();
        bus.Run = 1'b1;
        cyc(1'b0, 1'b0);
        close(1'b0);
        for (int i = 0; i < GF; i++) close(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Run = 1'b0; bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        bus.ship_pix = 1'b0; bus.obst_pix = 1'b0;
        bus.ship_x = 10'd100; bus.ship_y = 10'd100;
        Reset = 1'b1;

        do_reset();
        push_exp(1'b0, 2'b00, '0); check_out("reset_outputs");
        cmp("reset_state", 32'(bus.state), 32'(S_IDLE));

        // Reset arriving mid-frame with overlap in progress
        arm();
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t1_first_close");
        hits(3);
        Reset = 1'b1; bus.Run = 1'b0; cyc(1'b0, 1'b1); Reset = 1'b0;
        push_exp(1'b0, 2'b00, '0); check_out("t1_reset_mid_frame");
        cmp("t1_state_idle", 32'(bus.state), 32'(S_IDLE));
        push_exp(1'b0, 2'b00, '0); close(1'b1); check_out("t1_idle_pulse_ignored");
        cmp("t1_state_still_idle", 32'(bus.state), 32'(S_IDLE));

        // Two consecutive hit frames
        bus.Run = 1'b1; cyc(1'b0, 1'b0);
        cmp("t2_state_armed", 32'(bus.state), 32'(S_ARMED));
        close(1'b0);
        for (int i = 0; i < GF; i++) close(1'b0);
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t2_hit1");
        hits(5); push_exp(1'b1, 2'b01, 12'd5); close(1'b0); check_out("t2_hit2_crash");
        cmp("t2_state_crashed", 32'(bus.state), 32'(S_CRASHED));
        bus.Run = 1'b0; hits(6); push_exp(1'b1, 2'b01, 12'd5); close(1'b1); check_out("t2_sticky");

        // Hit, clean, hit, then a threshold-exact frame
        do_reset(); arm();
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t3_hit");
        hits(3); push_exp(1'b0, 2'b00, 12'd3); close(1'b0); check_out("t3_clean");
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t3_hit_again");
        hits(4); push_exp(1'b1, 2'b01, 12'd4); close(1'b0); check_out("t3_thresh_crash");

        // Boundary: last legal position, then x one past
        do_reset(); arm();
        push_exp(1'b0, 2'b00, '0); close(1'b0, 10'd639, 10'd479); check_out("t4_edge_legal");
        push_exp(1'b1, 2'b10, '0); close(1'b0, 10'd640, 10'd100); check_out("t4_x_out");
        do_reset(); arm();
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t4_hit1");
        hits(5); push_exp(1'b1, 2'b11, 12'd5); close(1'b0, 10'd100, 10'd480); check_out("t4_both_causes");

        // Strobe-cycle pixel goes to the new frame; accumulator saturation
        do_reset(); arm();
        hits(3); push_exp(1'b0, 2'b00, 12'd3); close(1'b1); check_out("t5_strobe_pixel_excluded");
        hits(2); push_exp(1'b0, 2'b00, 12'd3); close(1'b0); check_out("t5_acc_started_at_1");
        hits(4096); push_exp(1'b0, 2'b00, 12'd4095); close(1'b0); check_out("t5_saturate");
        hits(5); bus.Run = 1'b0; push_exp(1'b0, 2'b00, 12'd4095); close(1'b1); check_out("t5_run_drop_wins");
        cmp("t5_state_idle", 32'(bus.state), 32'(S_IDLE));
        arm();
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t5_consec_cleared");
        hits(5); push_exp(1'b1, 2'b01, 12'd5); close(1'b0); check_out("t5_crash_after_rearm");

        // Hit frames straight after sync: suppressed only while grace runs
        do_reset();
        bus.Run = 1'b1; cyc(1'b0, 1'b0); close(1'b0);
        for (int i = 0; i < GF; i++) begin
            hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t6_grace_hit");
        end
        hits(5); push_exp(1'b0, 2'b00, 12'd5); close(1'b0); check_out("t6_first_eval");
        hits(5); push_exp(1'b1, 2'b01, 12'd5); close(1'b0); check_out("t6_crash");

        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
